// File: rtl/multiword_add_pkg.sv
// Shared types and sizing helpers for the byte-serial multiword adder.
package multiword_add_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam int SLICE_W = 8;

  function automatic int calc_nslice(input int width);
    return width / SLICE_W;
  endfunction

  // A single-slice build still needs a 1-bit index register.
  function automatic int calc_idx_w(input int nslice);
    return (nslice > 1) ? $clog2(nslice) : 1;
  endfunction

endpackage

// File: rtl/adder_slice8.sv
// Combinational 8-bit ripple-carry adder built from full-adder cells.
module adder_slice8 (
  input  logic [7:0] a_i,
  input  logic [7:0] b_i,
  input  logic       cin_i,
  output logic [7:0] sum_o,
  output logic       cout_o
);

  logic [8:0] carry_s;

  assign carry_s[0] = cin_i;

  for (genvar i = 0; i < 8; i++) begin : g_fa
    assign sum_o[i]       = a_i[i] ^ b_i[i] ^ carry_s[i];
    assign carry_s[i + 1] = (a_i[i] & b_i[i]) | (carry_s[i] & (a_i[i] ^ b_i[i]));
  end

  assign cout_o = carry_s[8];

endmodule

// File: rtl/multiword_add_ctrl.sv
// WIDTH-bit add/subtract sequenced one byte per cycle through a single
// shared 8-bit slice, with valid/ready handshakes on operands and result.
module multiword_add_ctrl #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             overflow,
  output logic             busy
);

  import multiword_add_pkg::*;

  localparam int NSLICE = calc_nslice(WIDTH);
  localparam int IDX_W  = calc_idx_w(NSLICE);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NSLICE - 1);

  state_e           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             carry_q, carry_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;

  logic [SLICE_W-1:0] slice_a_s, slice_b_s, slice_sum_s;
  logic               slice_cout_s;

  assign slice_a_s = a_q[SLICE_W*idx_q +: SLICE_W];
  assign slice_b_s = b_q[SLICE_W*idx_q +: SLICE_W];

  adder_slice8 u_slice (
    .a_i    (slice_a_s),
    .b_i    (slice_b_s),
    .cin_i  (carry_q),
    .sum_o  (slice_sum_s),
    .cout_o (slice_cout_s)
  );

  // Next-state logic: operand capture, per-slice accumulation, result hold.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    carry_d = carry_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_d     = a;
          b_d     = sub ? ~b : b;
          carry_d = sub;
          idx_d   = '0;
          sum_d   = '0;
          cout_d  = 1'b0;
          ovf_d   = 1'b0;
          state_d = RUN;
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        sum_d[SLICE_W*idx_q +: SLICE_W] = slice_sum_s;
        carry_d = slice_cout_s;
        if (idx_q == LAST_IDX) begin
          // Overflow uses the top result bit produced by this final slice.
          cout_d  = slice_cout_s;
          ovf_d   = (a_q[WIDTH-1] == b_q[WIDTH-1]) && (slice_sum_s[SLICE_W-1] != a_q[WIDTH-1]);
          idx_d   = '0;
          state_d = DONE;
        end else begin
          idx_d   = idx_q + IDX_W'(1);
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end else begin
          state_d = DONE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q != IDLE);
  assign sum       = sum_q;
  assign cout      = cout_q;
  assign overflow  = ovf_q;

endmodule

// File: tb/tb_multiword_add_ctrl.sv
// Directed, table-driven bench for the 32-bit byte-serial add/subtract sequencer.
module tb_multiword_add_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] a, b;
  logic        sub;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] sum;
  logic        cout;
  logic        overflow;
  logic        busy;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        sub;
    logic [31:0] exp_sum;
    logic        exp_cout;
    logic        exp_ovf;
  } vec_t;

  vec_t vecs [0:8];

  multiword_add_ctrl #(.WIDTH(32)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .sub       (sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
    .overflow  (overflow),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Present operands for one cycle; returns after the accept edge.
  task automatic accept(input logic [31:0] av, input logic [31:0] bv, input logic sv);
    chk("in_ready_before_accept", {31'd0, in_ready}, 32'd1);
    in_valid = 1'b1; a = av; b = bv; sub = sv;
    @(negedge clk);
    in_valid = 1'b0; a = 32'hDEAD_BEEF; b = 32'hCAFE_F00D; sub = 1'b0;
  endtask

  // Count cycles to out_valid, checking in_ready stays low while running.
  task automatic wait_result(input string tag);
    int lat = 0;
    while (!out_valid && lat < 20) begin
      chk({tag, "_in_ready_run"}, {31'd0, in_ready}, 32'd0);
      lat++;
      @(negedge clk);
    end
    chk({tag, "_latency"}, lat, 32'd4);
  endtask

  task automatic check_result(input string tag, input vec_t v);
    chk({tag, "_out_valid"}, {31'd0, out_valid}, 32'd1);
    chk({tag, "_sum"}, sum, v.exp_sum);
    chk({tag, "_cout"}, {31'd0, cout}, {31'd0, v.exp_cout});
    chk({tag, "_ovf"}, {31'd0, overflow}, {31'd0, v.exp_ovf});
  endtask

  task automatic handshake(input string tag);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk({tag, "_out_valid_after_hs"}, {31'd0, out_valid}, 32'd0);
    chk({tag, "_in_ready_after_hs"}, {31'd0, in_ready}, 32'd1);
  endtask

  initial begin
    vec_t v;
    vecs[0] = '{32'h0000_00FF, 32'h0000_0001, 1'b0, 32'h0000_0100, 1'b0, 1'b0};
    vecs[1] = '{32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 32'h0000_0000, 1'b1, 1'b0};
    vecs[2] = '{32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 32'h8000_0000, 1'b0, 1'b1};
    vecs[3] = '{32'h8000_0000, 32'h0000_0001, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1};
    vecs[4] = '{32'h1234_5678, 32'h9ABC_DEF0, 1'b0, 32'hACF1_3568, 1'b0, 1'b0};
    vecs[5] = '{32'h0000_1234, 32'h0000_1234, 1'b1, 32'h0000_0000, 1'b1, 1'b0};
    vecs[6] = '{32'h0000_0000, 32'h0000_0001, 1'b1, 32'hFFFF_FFFF, 1'b0, 1'b0};
    vecs[7] = '{32'h8000_0000, 32'h8000_0000, 1'b0, 32'h0000_0000, 1'b1, 1'b1};
    vecs[8] = '{32'h0000_0001, 32'h0000_0002, 1'b0, 32'h0000_0003, 1'b0, 1'b0};

    rst_n = 1'b0; in_valid = 1'b0; a = '0; b = '0; sub = 1'b0; out_ready = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_sum", sum, 32'd0);
    chk("rst_cout", {31'd0, cout}, 32'd0);
    chk("rst_ovf", {31'd0, overflow}, 32'd0);

    for (int i = 0; i < 9; i++) begin
      accept(vecs[i].a, vecs[i].b, vecs[i].sub);
      chk($sformatf("v%0d_busy", i), {31'd0, busy}, 32'd1);
      wait_result($sformatf("v%0d", i));
      check_result($sformatf("v%0d", i), vecs[i]);
      handshake($sformatf("v%0d", i));
    end

    // 5 - 7 with a stray in_valid pulse during RUN.
    v = '{32'h0000_0005, 32'h0000_0007, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0};
    accept(v.a, v.b, v.sub);
    chk("stray_in_ready_run0", {31'd0, in_ready}, 32'd0);
    @(negedge clk);
    in_valid = 1'b1; a = 32'h0000_0100; b = 32'h0000_0100; sub = 1'b0;
    chk("stray_in_ready_run1", {31'd0, in_ready}, 32'd0);
    @(negedge clk);
    in_valid = 1'b0;
    chk("stray_in_ready_run2", {31'd0, in_ready}, 32'd0);
    @(negedge clk);
    chk("stray_in_ready_run3", {31'd0, in_ready}, 32'd0);
    @(negedge clk);
    check_result("stray", v);
    handshake("stray");
    @(negedge clk);
    chk("stray_no_second_op", {31'd0, busy}, 32'd0);

    // Back-pressure: result must hold for three stalled cycles.
    v = vecs[4];
    accept(v.a, v.b, v.sub);
    wait_result("bp");
    for (int k = 0; k < 3; k++) begin
      check_result($sformatf("bp_stall%0d", k), v);
      @(negedge clk);
    end
    check_result("bp_stall3", v);
    handshake("bp");

    // Reset while RUN at idx 2 abandons the operation.
    accept(32'hFFFF_FFFF, 32'h0000_0001, 1'b0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk("abort_in_ready", {31'd0, in_ready}, 32'd1);
    chk("abort_busy", {31'd0, busy}, 32'd0);
    chk("abort_out_valid", {31'd0, out_valid}, 32'd0);
    chk("abort_sum", sum, 32'd0);
    chk("abort_cout", {31'd0, cout}, 32'd0);
    chk("abort_ovf", {31'd0, overflow}, 32'd0);
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      chk($sformatf("abort_no_valid%0d", k), {31'd0, out_valid}, 32'd0);
    end
    v = vecs[8];
    accept(v.a, v.b, v.sub);
    wait_result("post_abort");
    check_result("post_abort", v);
    handshake("post_abort");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
